// File: rtl/mem_bridge.sv
// mem_bridge: sequences a core's instruction fetch and optional data access
// over one single-port memory bus. Each core step runs FETCH, then DATA if
// the core requested a data access, then STEP. STEP pulses clk_en for one
// cycle to advance the core. A memory that does not acknowledge within
// TIMEOUT cycles is abandoned: a NOP (fetch) or zero (load) is returned and
// the sticky bus_err flag is set.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   inst_addr         core fetch word address
//   data_addr         core data word address
//   core_dreq         core data access request
//   core_dwe          core data write enable
//   core_mask         byte-lane mask for the data access
//   core_wdata        core store data
//   clk_en            core advance strobe (one cycle, in STEP)
//   inst_in, data_in  registered fetched instruction / loaded data
//   bus_req, bus_we, bus_addr, bus_mask, bus_wdata   memory request
//   bus_ack, bus_rdata                               memory completion
//   bus_err           sticky timeout flag
module mem_bridge #(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] inst_addr,
  input  logic [29:0] data_addr,
  input  logic        core_dreq,
  input  logic        core_dwe,
  input  logic [3:0]  core_mask,
  input  logic [31:0] core_wdata,
  output logic        clk_en,
  output logic [31:0] inst_in,
  output logic [31:0] data_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_mask,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {FETCH, DATA, STEP} state_t;

  // The wait counter value during the last cycle an ack is still accepted.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        run;
  logic [7:0]  wait_cnt;
  logic [31:0] inst_q, data_q;
  logic        active, acked, abort, done;

  // run holds the bus quiet until the first clock edge after reset release,
  // so a stale ack from an access abandoned by reset is never taken.
  assign active = run && (state == FETCH || state == DATA);
  assign acked  = active && bus_ack;
  assign abort  = active && !bus_ack && (wait_cnt == TO_LAST);
  assign done   = acked || abort;

  assign bus_req = active;
  assign inst_in = inst_q;
  assign data_in = data_q;

  always_comb begin
    state_nxt = state;
    clk_en    = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = inst_addr;
    bus_mask  = 4'hF;
    bus_wdata = core_wdata;
    case (state)
      FETCH: begin
        if (done) state_nxt = core_dreq ? DATA : STEP;
      end
      DATA: begin
        bus_we   = core_dwe;
        bus_addr = data_addr;
        bus_mask = core_mask;
        if (done) state_nxt = STEP;
      end
      STEP: begin
        clk_en    = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      run      <= 1'b0;
      wait_cnt <= 8'd0;
      bus_err  <= 1'b0;
      inst_q   <= NOP;
      data_q   <= 32'd0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      // Clearing on completion and while idle makes every access start at 0.
      if (done || !active) wait_cnt <= 8'd0;
      else                 wait_cnt <= wait_cnt + 8'd1;
      if (abort) bus_err <= 1'b1;
      if (state == FETCH) begin
        if (acked)      inst_q <= bus_rdata;
        else if (abort) inst_q <= NOP;
      end
      if (state == DATA) begin
        if (acked && !core_dwe) data_q <= bus_rdata;
        else if (abort)         data_q <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Testbench for mem_bridge: directed scenarios followed by randomized core
// steps, compared against a transaction-level model of what each step must
// return to the core.
module tb_mem_bridge;

  localparam int          TO    = 4;
  localparam logic [31:0] NOP_V = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] inst_addr = '0;
  logic [29:0] data_addr = '0;
  logic        core_dreq = 1'b0;
  logic        core_dwe = 1'b0;
  logic [3:0]  core_mask = 4'hF;
  logic [31:0] core_wdata = '0;
  logic        clk_en;
  logic [31:0] inst_in;
  logic [31:0] data_in;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_mask;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_inst = NOP_V;
  logic [31:0] exp_data = 32'd0;
  logic        exp_err  = 1'b0;

  mem_bridge #(.TIMEOUT(TO), .NOP(NOP_V)) dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .data_addr(data_addr),
    .core_dreq(core_dreq), .core_dwe(core_dwe),
    .core_mask(core_mask), .core_wdata(core_wdata),
    .clk_en(clk_en), .inst_in(inst_in), .data_in(data_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_mask(bus_mask), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_clk_en", 32'(clk_en), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_inst", inst_in, NOP_V);
    chk("rst_data", data_in, 32'd0);
  endtask

  // Memory side of one access: ack is given in cycle k of the access (1-based);
  // a k beyond TO means the memory never answers within the window.
  task automatic access(input logic [29:0] addr, input logic we, input logic [3:0] mask,
                        input logic [31:0] wdata, input int k, input logic [31:0] rdata,
                        input bit is_fetch, input logic final_dreq);
    for (int cyc = 1; cyc <= TO; cyc++) begin
      @(negedge clk);
      bus_ack   = (cyc == k);
      bus_rdata = (cyc == k) ? rdata : $urandom;
      if (is_fetch) begin
        // Only the value at fetch completion may matter.
        core_dreq = (cyc == k || cyc == TO) ? final_dreq : 1'($urandom);
        core_dwe  = 1'($urandom);
      end else begin
        core_dreq = 1'b1;
        core_dwe  = we;
      end
      #1;
      chk(is_fetch ? "f_req" : "d_req", 32'(bus_req), 32'd1);
      chk(is_fetch ? "f_addr" : "d_addr", 32'(bus_addr), 32'(addr));
      chk(is_fetch ? "f_we" : "d_we", 32'(bus_we), 32'(we));
      chk(is_fetch ? "f_mask" : "d_mask", 32'(bus_mask), 32'(mask));
      if (we) chk("d_wdata", bus_wdata, wdata);
      chk("busy_clk_en", 32'(clk_en), 32'd0);
      if (cyc == k) break;
    end
  endtask

  task automatic do_step(input bit dreq, input bit dwe, input int kf, input int kd,
                         input logic [31:0] rf, input logic [31:0] rd);
    logic we_v;
    we_v = dwe;
    access(inst_addr, 1'b0, 4'hF, 32'd0, kf, rf, 1'b1, dreq);
    if (kf <= TO) exp_inst = rf;
    else begin exp_inst = NOP_V; exp_err = 1'b1; end
    if (dreq) begin
      access(data_addr, we_v, core_mask, core_wdata, kd, rd, 1'b0, 1'b1);
      if (kd > TO) begin exp_data = 32'd0; exp_err = 1'b1; end
      else if (!dwe) exp_data = rd;
    end
    // STEP cycle: an ack here must be ignored.
    @(negedge clk);
    bus_ack   = 1'($urandom);
    bus_rdata = $urandom;
    core_dreq = 1'($urandom);
    #1;
    chk("step_clk_en", 32'(clk_en), 32'd1);
    chk("step_req", 32'(bus_req), 32'd0);
    chk("step_inst", inst_in, exp_inst);
    chk("step_data", data_in, exp_data);
    chk("step_err", 32'(bus_err), 32'(exp_err));
  endtask

  initial begin
    // Reset state, then release with a stale ack present before the first edge.
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals();
    bus_ack = 1'b1;
    bus_rdata = 32'hBAD0_BAD0;
    rst = 1'b1;
    #1;
    chk("rel_req", 32'(bus_req), 32'd0);

    // Fetch-only steps, period 3.
    inst_addr = 30'h100;
    for (int i = 0; i < 3; i++) do_step(1'b0, 1'b0, 2, 1, 32'h0050_0093, 32'd0);

    // Load: fetch then data at 0x10, period 4.
    data_addr = 30'h10;
    do_step(1'b1, 1'b0, 2, 1, 32'h0000_2083, 32'hDEAD_BEEF);

    // Store with partial mask and a slow memory; data_in must not change.
    core_mask = 4'b0011;
    core_wdata = 32'h1234_ABCD;
    do_step(1'b1, 1'b1, 2, 3, 32'h0011_2023, 32'h5555_5555);

    // Ack on the last accepted cycle still succeeds.
    core_mask = 4'hF;
    do_step(1'b0, 1'b0, TO, 1, 32'h0000_0073, 32'd0);

    // Fetch never acked: NOP, sticky error.
    do_step(1'b0, 1'b0, TO + 1, 1, 32'hFFFF_FFFF, 32'd0);
    do_step(1'b0, 1'b0, 2, 1, 32'h0000_0093, 32'd0);

    // Randomized steps.
    for (int i = 0; i < 150; i++) begin
      inst_addr  = 30'($urandom);
      data_addr  = 30'($urandom);
      core_mask  = 4'($urandom);
      core_wdata = $urandom;
      do_step(1'($urandom), 1'($urandom), $urandom_range(2, TO + 1),
              $urandom_range(1, TO + 1), $urandom, $urandom);
    end

    // Reset while a load is waiting on the memory.
    inst_addr = 30'h2A;
    data_addr = 30'h3C;
    core_mask = 4'hF;
    access(inst_addr, 1'b0, 4'hF, 32'd0, 2, 32'h0000_0003, 1'b1, 1'b1);
    @(negedge clk);
    bus_ack = 1'b0;
    core_dreq = 1'b1;
    core_dwe = 1'b0;
    #1;
    chk("mid_addr", 32'(bus_addr), 32'h3C);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals();
    exp_inst = NOP_V;
    exp_data = 32'd0;
    exp_err  = 1'b0;
    @(negedge clk);
    bus_ack = 1'b1;
    rst = 1'b1;
    #1;
    chk("rel2_req", 32'(bus_req), 32'd0);
    do_step(1'b0, 1'b0, 2, 1, 32'h0000_1111, 32'd0);

    for (int i = 0; i < 50; i++) begin
      inst_addr  = 30'($urandom);
      data_addr  = 30'($urandom);
      core_mask  = 4'($urandom);
      core_wdata = $urandom;
      do_step(1'($urandom), 1'($urandom), $urandom_range(2, TO + 1),
              $urandom_range(1, TO + 1), $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
